// File: rtl/ps2_cursor_tracker.sv
// ps2_cursor_tracker
// Assembles PS/2 mouse bytes into 3-byte (standard) or 4-byte (IntelliMouse)
// packets and maintains a cursor position clamped to the visible screen,
// together with button and wheel state.
//
// Ports:
//   clk          - system clock (50 MHz domain)
//   reset        - synchronous, active-high
//   mouse_data   - received PS/2 byte
//   mouse_valid  - one-cycle strobe qualifying mouse_data
//   cursor_x/y   - cursor column/row (row 0 = top), clamped to the screen
//   btn_*        - button state from the last good packet
//   wheel_delta  - signed wheel movement of the last packet (0 for 3-byte mode)
//   packet_valid - one-cycle pulse when the outputs above update
//   sync_error   - one-cycle pulse when a byte or partial packet is discarded
module ps2_cursor_tracker #(
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned X_INIT      = 320,
  parameter int unsigned Y_INIT      = 240,
  parameter int unsigned PKT_BYTES   = 3,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] mouse_data,
  input  logic       mouse_valid,
  output logic [9:0] cursor_x,
  output logic [9:0] cursor_y,
  output logic       btn_left,
  output logic       btn_right,
  output logic       btn_middle,
  output logic [3:0] wheel_delta,
  output logic       packet_valid,
  output logic       sync_error
);

  if (PKT_BYTES != 3 && PKT_BYTES != 4) begin : g_bad_pkt_bytes
    $error("ps2_cursor_tracker: PKT_BYTES must be 3 or 4");
  end

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT_CYC - 1);

  localparam logic [9:0] X_MAX10 = 10'(SCREEN_W - 1);
  localparam logic [9:0] Y_MAX10 = 10'(SCREEN_H - 1);
  localparam logic signed [11:0] X_MAX = {2'b00, X_MAX10};
  localparam logic signed [11:0] Y_MAX = {2'b00, Y_MAX10};
  localparam logic [9:0] X_RST = 10'(X_INIT);
  localparam logic [9:0] Y_RST = 10'(Y_INIT);

  typedef enum logic [1:0] {
    S_STATUS,
    S_DX,
    S_DY,
    S_DZ
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   idle_q, idle_d;
  logic [7:0]      stat_q, stat_d;
  logic [7:0]      bx_q, bx_d;
  logic [7:0]      by_q, by_d;
  logic [9:0]      cx_q, cx_d;
  logic [9:0]      cy_q, cy_d;
  logic [2:0]      btn_q, btn_d;
  logic [3:0]      wheel_q, wheel_d;
  logic            pkt_q, pkt_d;
  logic            err_q, err_d;

  // Bit 3 of the status byte is only the always-one sync marker.
  logic unused_stat_sync;
  assign unused_stat_sync = stat_q[3];

  logic                finish;
  logic [7:0]          byte_y;
  logic [8:0]          dx9, dy9;
  logic signed [11:0]  nx, ny;

  // In 3-byte mode the Y byte is the final byte and is still on mouse_data
  // when the packet completes; in 4-byte mode it was latched earlier.
  assign byte_y = (PKT_BYTES == 4) ? by_q : mouse_data;
  assign dx9    = stat_q[6] ? 9'd0 : {stat_q[4], bx_q};
  assign dy9    = stat_q[7] ? 9'd0 : {stat_q[5], byte_y};
  assign nx     = $signed({2'b00, cx_q}) + $signed({{3{dx9[8]}}, dx9});
  assign ny     = $signed({2'b00, cy_q}) - $signed({{3{dy9[8]}}, dy9});

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    stat_d  = stat_q;
    bx_d    = bx_q;
    by_d    = by_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    btn_d   = btn_q;
    wheel_d = wheel_q;
    pkt_d   = 1'b0;
    err_d   = 1'b0;
    finish  = 1'b0;

    if (state_q == S_STATUS) begin
      idle_d = '0;
      if (mouse_valid) begin
        if (mouse_data[3]) begin
          stat_d  = mouse_data;
          state_d = S_DX;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (mouse_valid) begin
      idle_d = '0;
      case (state_q)
        S_DX: begin
          bx_d    = mouse_data;
          state_d = S_DY;
        end
        S_DY: begin
          if (PKT_BYTES == 4) begin
            by_d    = mouse_data;
            state_d = S_DZ;
          end else begin
            finish  = 1'b1;
            state_d = S_STATUS;
          end
        end
        default: begin
          finish  = 1'b1;
          state_d = S_STATUS;
        end
      endcase
    end else if (idle_q == IDLE_LAST) begin
      state_d = S_STATUS;
      idle_d  = '0;
      err_d   = 1'b1;
    end else begin
      idle_d = idle_q + 1'b1;
    end

    if (finish) begin
      pkt_d = 1'b1;
      btn_d = stat_q[2:0];
      if (nx[11])          cx_d = '0;
      else if (nx > X_MAX) cx_d = X_MAX10;
      else                 cx_d = nx[9:0];
      if (ny[11])          cy_d = '0;
      else if (ny > Y_MAX) cy_d = Y_MAX10;
      else                 cy_d = ny[9:0];
      wheel_d = (PKT_BYTES == 4) ? mouse_data[3:0] : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_STATUS;
      idle_q  <= '0;
      stat_q  <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      cx_q    <= X_RST;
      cy_q    <= Y_RST;
      btn_q   <= '0;
      wheel_q <= '0;
      pkt_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      stat_q  <= stat_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      btn_q   <= btn_d;
      wheel_q <= wheel_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
    end
  end

  assign cursor_x     = cx_q;
  assign cursor_y     = cy_q;
  assign btn_left     = btn_q[0];
  assign btn_right    = btn_q[1];
  assign btn_middle   = btn_q[2];
  assign wheel_delta  = wheel_q;
  assign packet_valid = pkt_q;
  assign sync_error   = err_q;

endmodule

// File: tb/tb_ps2_cursor_tracker.sv
// Testbench for ps2_cursor_tracker: one 3-byte and one 4-byte instance,
// expected events queued by a packet-level model, checked by a monitor.
module tb_ps2_cursor_tracker;

  localparam int unsigned TO = 40;

  logic clk;
  initial clk = 1'b0;
  always #10 clk = ~clk;

  logic [1:0]       rst;
  logic [1:0][7:0]  md;
  logic [1:0]       mv;
  logic [1:0][9:0]  cx, cy;
  logic [1:0]       bl, br, bm;
  logic [1:0][3:0]  wd;
  logic [1:0]       pv, se;

  ps2_cursor_tracker #(.SCREEN_W(640), .SCREEN_H(480), .X_INIT(320), .Y_INIT(240),
                       .PKT_BYTES(3), .TIMEOUT_CYC(TO)) u_p3 (
    .clk(clk), .reset(rst[0]), .mouse_data(md[0]), .mouse_valid(mv[0]),
    .cursor_x(cx[0]), .cursor_y(cy[0]), .btn_left(bl[0]), .btn_right(br[0]),
    .btn_middle(bm[0]), .wheel_delta(wd[0]), .packet_valid(pv[0]), .sync_error(se[0]));

  ps2_cursor_tracker #(.SCREEN_W(640), .SCREEN_H(480), .X_INIT(320), .Y_INIT(240),
                       .PKT_BYTES(4), .TIMEOUT_CYC(TO)) u_p4 (
    .clk(clk), .reset(rst[1]), .mouse_data(md[1]), .mouse_valid(mv[1]),
    .cursor_x(cx[1]), .cursor_y(cy[1]), .btn_left(bl[1]), .btn_right(br[1]),
    .btn_middle(bm[1]), .wheel_delta(wd[1]), .packet_valid(pv[1]), .sync_error(se[1]));

  typedef struct {
    bit       is_pkt;
    int       x;
    int       y;
    bit [2:0] btn;
    bit [3:0] wheel;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  int       mx[2];
  int       my[2];
  bit [7:0] pb[2][4];
  int       pn[2];

  // Monitor's record of what the outputs should hold between pulses
  int       rx[2];
  int       ry[2];
  bit [2:0] rb[2];
  bit [3:0] rw[2];

  function automatic int clampi(int v, int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic push_exp(input int idx, input exp_t e);
    if (idx == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  task automatic push_err(input int idx);
    exp_t e;
    e.is_pkt = 1'b0; e.x = 0; e.y = 0; e.btn = '0; e.wheel = '0;
    push_exp(idx, e);
  endtask

  task automatic model_byte(input int idx, input bit [7:0] b);
    int plen;
    int dx, dy;
    bit [7:0] s;
    exp_t e;
    plen = (idx == 0) ? 3 : 4;
    if (pn[idx] == 0) begin
      if (!b[3]) push_err(idx);
      else begin
        pb[idx][0] = b;
        pn[idx] = 1;
      end
    end else begin
      pb[idx][pn[idx]] = b;
      pn[idx]++;
      if (pn[idx] == plen) begin
        s  = pb[idx][0];
        dx = s[6] ? 0 : (s[4] ? int'(pb[idx][1]) - 256 : int'(pb[idx][1]));
        dy = s[7] ? 0 : (s[5] ? int'(pb[idx][2]) - 256 : int'(pb[idx][2]));
        mx[idx] = clampi(mx[idx] + dx, 639);
        my[idx] = clampi(my[idx] - dy, 479);
        e.is_pkt = 1'b1;
        e.x = mx[idx];
        e.y = my[idx];
        e.btn = s[2:0];
        e.wheel = (plen == 4) ? pb[idx][3][3:0] : 4'd0;
        push_exp(idx, e);
        pn[idx] = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Send one byte after `gap` idle cycles since the previous byte.
  task automatic send(input int idx, input bit [7:0] b, input int gap);
    if (pn[idx] != 0 && gap >= int'(TO)) begin
      push_err(idx);
      pn[idx] = 0;
    end
    idle(gap);
    md[idx] = b;
    mv[idx] = 1'b1;
    model_byte(idx, b);
    @(posedge clk);
    #1;
    mv[idx] = 1'b0;
  endtask

  task automatic flush(input int idx);
    if (pn[idx] != 0) begin
      push_err(idx);
      pn[idx] = 0;
    end
    idle(int'(TO) + 4);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_xy(input int idx, input int x, input int y);
    @(negedge clk);
    chk("directed_x", int'(cx[idx]), x);
    chk("directed_y", int'(cy[idx]), y);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int idx);
    idle(2);
    rst[idx] = 1'b1;
    pn[idx] = 0;
    mx[idx] = 320;
    my[idx] = 240;
    idle(2);
    rst[idx] = 1'b0;
    @(negedge clk);
    chk("reset_x", int'(cx[idx]), 320);
    chk("reset_y", int'(cy[idx]), 240);
    chk("reset_btn", int'({bm[idx], br[idx], bl[idx]}), 0);
    chk("reset_wheel", int'(wd[idx]), 0);
    chk("reset_pulses", int'({pv[idx], se[idx]}), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic mon(input int i);
    exp_t e;
    bit have;
    if (rst[i]) begin
      rx[i] = 320; ry[i] = 240; rb[i] = '0; rw[i] = '0;
      return;
    end
    if (pv[i] || se[i]) begin
      have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL unexpected_pulse inst%0d: packet_valid=%b sync_error=%b, expected no pulse",
                 i, pv[i], se[i]);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        if (e.is_pkt) begin
          if (!(pv[i] && !se[i] && int'(cx[i]) == e.x && int'(cy[i]) == e.y &&
                {bm[i], br[i], bl[i]} == e.btn && wd[i] == e.wheel)) begin
            errors++;
            $display("FAIL packet inst%0d: got pv=%b se=%b x=%0d y=%0d btn=%b wheel=%h, expected pv=1 se=0 x=%0d y=%0d btn=%b wheel=%h",
                     i, pv[i], se[i], cx[i], cy[i], {bm[i], br[i], bl[i]}, wd[i],
                     e.x, e.y, e.btn, e.wheel);
          end
          rx[i] = e.x; ry[i] = e.y; rb[i] = e.btn; rw[i] = e.wheel;
        end else if (!(se[i] && !pv[i])) begin
          errors++;
          $display("FAIL sync_err inst%0d: got pv=%b se=%b, expected pv=0 se=1", i, pv[i], se[i]);
        end
      end
    end
    checks++;
    if (int'(cx[i]) != rx[i] || int'(cy[i]) != ry[i] ||
        {bm[i], br[i], bl[i]} != rb[i] || wd[i] != rw[i]) begin
      errors++;
      $display("FAIL hold inst%0d: got x=%0d y=%0d btn=%b wheel=%h, expected x=%0d y=%0d btn=%b wheel=%h",
               i, cx[i], cy[i], {bm[i], br[i], bl[i]}, wd[i], rx[i], ry[i], rb[i], rw[i]);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) mon(i);
  end

  task automatic random_phase(input int idx, input int nbytes);
    bit [7:0] b;
    int gap;
    for (int k = 0; k < nbytes; k++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset(idx);
      end else begin
        b = 8'($urandom);
        if (pn[idx] == 0 && $urandom_range(0, 99) < 90) b[3] = 1'b1;
        if ($urandom_range(0, 24) == 0) gap = int'(TO) + int'($urandom_range(0, 4));
        else                            gap = int'($urandom_range(0, 3));
        send(idx, b, gap);
      end
    end
    flush(idx);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 2'b11;
    mv  = '0;
    md  = '0;
    for (int i = 0; i < 2; i++) begin
      mx[i] = 320; my[i] = 240; pn[i] = 0;
      rx[i] = 320; ry[i] = 240; rb[i] = '0; rw[i] = '0;
    end
    @(posedge clk);
    #1;
    idle(2);
    rst = 2'b00;
    do_reset(0);
    do_reset(1);

    // Single packet
    send(0, 8'h09, 0); send(0, 8'h05, 0); send(0, 8'h03, 0);
    check_xy(0, 325, 237);
    do_reset(0);
    // Negative X delta
    send(0, 8'h18, 0); send(0, 8'hF6, 0); send(0, 8'h00, 0);
    check_xy(0, 310, 240);
    do_reset(0);
    // Clamping on the right edge, then the top edge
    for (int k = 0; k < 3; k++) begin
      send(0, 8'h08, 0); send(0, 8'h7F, 0); send(0, 8'h00, 0);
    end
    check_xy(0, 639, 240);
    for (int k = 0; k < 2; k++) begin
      send(0, 8'h08, 0); send(0, 8'h00, 0); send(0, 8'h7F, 0);
    end
    check_xy(0, 639, 0);
    do_reset(0);
    // Bad status byte, then a good packet, then X overflow
    send(0, 8'h00, 0);
    send(0, 8'h08, 1); send(0, 8'h01, 0); send(0, 8'h01, 0);
    check_xy(0, 321, 239);
    send(0, 8'h48, 0); send(0, 8'h10, 0); send(0, 8'h02, 0);
    check_xy(0, 321, 237);
    // Timeout mid-packet, next packet realigns
    send(0, 8'h08, 0); send(0, 8'h05, 0);
    send(0, 8'h08, int'(TO) + 2); send(0, 8'h02, 0); send(0, 8'h00, 0);
    check_xy(0, 323, 237);
    // Gap one short of the timeout keeps the packet
    send(0, 8'h08, 0); send(0, 8'h01, int'(TO) - 1); send(0, 8'h00, 0);
    // Gap equal to the timeout discards it
    send(0, 8'h08, 0); send(0, 8'h01, int'(TO));
    send(0, 8'h00, 0);
    // Reset mid-packet discards the partial packet
    send(0, 8'h08, 0); send(0, 8'h05, 0);
    do_reset(0);
    send(0, 8'h08, 0); send(0, 8'h01, 0); send(0, 8'h01, 0);
    check_xy(0, 321, 239);

    // Wheel byte in 4-byte mode
    send(1, 8'h08, 0); send(1, 8'h00, 0); send(1, 8'h00, 0); send(1, 8'h0F, 0);
    send(1, 8'h0B, 0); send(1, 8'hFE, 0); send(1, 8'h03, 0); send(1, 8'h01, 0);
    send(1, 8'h08, 0); send(1, 8'h01, 0); send(1, 8'h01, 0);
    flush(1);

    random_phase(0, 500);
    random_phase(1, 500);
    idle(4);

    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
